// File: rtl/posit_window_collector.sv
// Collects framed posit accumulator words and queues one {length, final posit}
// result per complete window in a small FIFO for the downstream consumer.
module posit_window_collector #(
    parameter int POSIT_WIDTH = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int LEN_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rts_i,
    input  logic                   sow_i,
    input  logic                   eow_i,
    input  logic [POSIT_WIDTH-1:0] data_i,
    output logic                   rtr_o,
    output logic                   rts_o,
    output logic [POSIT_WIDTH-1:0] data_o,
    output logic [LEN_W-1:0]       len_o,
    input  logic                   rtr_i,
    output logic                   err_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = LEN_W + POSIT_WIDTH;
    localparam logic [LEN_W-1:0] LEN_MAX  = '1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        IN_WIN
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, len_word;
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              rtr_q, rtr_d;
    logic              err_q, err_d;
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
    logic              accept, push, pop;

    always_comb begin
        accept   = rts_i && rtr_q;
        pop      = (occ_q != '0) && rtr_i;
        // Length of the window including the word currently presented.
        len_word = sow_i ? LEN_W'(1) : ((len_q == LEN_MAX) ? len_q : len_q + 1'b1);
        push     = accept && eow_i && (sow_i || (state_q == IN_WIN));

        state_d = state_q;
        len_d   = len_q;
        err_d   = err_q;
        if (accept) begin
            if (sow_i) begin
                len_d   = len_word;
                if (state_q == IN_WIN) err_d = 1'b1;
                state_d = eow_i ? IDLE : IN_WIN;
            end else if (state_q == IN_WIN) begin
                len_d = len_word;
                if (eow_i) state_d = IDLE;
            end else begin
                err_d = 1'b1;
            end
        end

        wr_d = wr_q;
        if (push) wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
        rd_d = rd_q;
        if (pop) rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + 1'b1;

        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        rtr_d = (occ_d < OCC_FULL);

        mem_d = mem_q;
        if (push) mem_d[wr_q] = {len_word, data_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
            rtr_q   <= 1'b0;
            err_q   <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            occ_q   <= occ_d;
            rtr_q   <= rtr_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    assign rtr_o            = rtr_q;
    assign rts_o            = (occ_q != '0);
    assign {len_o, data_o}  = mem_q[rd_q];
    assign err_o            = err_q;

endmodule

// File: tb/tb_posit_window_collector.sv
// Directed bench for posit_window_collector with a queue-based window model
// checked every cycle plus hand-computed expectations per scenario.
module tb_posit_window_collector;

    localparam int PW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 8;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          rts_i  = 1'b0;
    logic          sow_i  = 1'b0;
    logic          eow_i  = 1'b0;
    logic          rtr_i  = 1'b0;
    logic [PW-1:0] data_i = '0;
    logic          rtr_o, rts_o, err_o;
    logic [PW-1:0] data_o;
    logic [LW-1:0] len_o;

    int n_checks = 0;
    int n_fail   = 0;
    int rts_hi   = 0;

    logic [15:0] m_q[$];
    logic [15:0] pop_log[$];
    bit          m_open = 1'b0;
    bit          m_err  = 1'b0;
    bit          m_rtr  = 1'b0;
    int          m_cnt  = 0;

    posit_window_collector #(
        .POSIT_WIDTH(PW),
        .FIFO_DEPTH (DEPTH),
        .LEN_W      (LW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rts_i (rts_i),
        .sow_i (sow_i),
        .eow_i (eow_i),
        .data_i(data_i),
        .rtr_o (rtr_o),
        .rts_o (rts_o),
        .data_o(data_o),
        .len_o (len_o),
        .rtr_i (rtr_i),
        .err_o (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] log_at(input int i);
        return (pop_log.size() > i) ? pop_log[i] : 16'hDEAD;
    endfunction

    // Window model: whole-window bookkeeping with a result queue.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_open = 1'b0;
            m_err  = 1'b0;
            m_cnt  = 0;
            m_rtr  = 1'b0;
        end else begin
            if (m_q.size() > 0 && rtr_i) void'(m_q.pop_front());
            if (rts_i && m_rtr) begin
                if (sow_i) begin
                    if (m_open) m_err = 1'b1;
                    m_cnt  = 1;
                    m_open = !eow_i;
                    if (eow_i) m_q.push_back({8'd1, data_i});
                end else if (!m_open) begin
                    m_err = 1'b1;
                end else begin
                    m_cnt++;
                    if (eow_i) begin
                        m_q.push_back({(m_cnt > 255) ? 8'd255 : 8'(m_cnt), data_i});
                        m_open = 1'b0;
                    end
                end
            end
            m_rtr = (m_q.size() < DEPTH);
        end
    end

    initial forever begin
        @(posedge clk);
        if (rst_n && rts_o) begin
            rts_hi++;
            if (rtr_i) pop_log.push_back({len_o, data_o});
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_rtr", 32'(rtr_o), 32'd0);
            check("rst_rts", 32'(rts_o), 32'd0);
            check("rst_data", 32'(data_o), 32'd0);
            check("rst_len", 32'(len_o), 32'd0);
            check("rst_err", 32'(err_o), 32'd0);
        end else begin
            check("cyc_rtr", 32'(rtr_o), 32'(m_rtr));
            check("cyc_rts", 32'(rts_o), 32'(m_q.size() > 0));
            check("cyc_err", 32'(err_o), 32'(m_err));
            if (m_q.size() > 0) begin
                check("cyc_data", 32'(data_o), 32'(m_q[0][7:0]));
                check("cyc_len", 32'(len_o), 32'(m_q[0][15:8]));
            end
        end
    end

    task automatic send(input bit s, input bit e, input logic [7:0] d);
        int waited = 0;
        @(negedge clk);
        rts_i  = 1'b1;
        sow_i  = s;
        eow_i  = e;
        data_i = d;
        while (!rtr_o && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("send_accept", 32'(rtr_o), 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        rts_i = 1'b0;
        sow_i = 1'b0;
        eow_i = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_rtr", 32'(rtr_o), 32'd1);
        check("post_reset_rts", 32'(rts_o), 32'd0);

        // Three-word window, drained immediately.
        rtr_i = 1'b1;
        pop_log.delete();
        rts_hi = 0;
        send(1'b1, 1'b0, 8'h10);
        send(1'b0, 1'b0, 8'h20);
        send(1'b0, 1'b1, 8'h35);
        idle();
        check("w3_lat_rts", 32'(rts_o), 32'd1);
        check("w3_data", 32'(data_o), 32'h35);
        check("w3_len", 32'(len_o), 32'd3);
        repeat (3) @(negedge clk);
        check("w3_count", 32'(pop_log.size()), 32'd1);
        check("w3_entry", 32'(log_at(0)), 32'h0335);
        check("w3_rts_cycles", 32'(rts_hi), 32'd1);
        check("w3_err", 32'(err_o), 32'd0);

        // Single-word window, then a clean 2-word window proves FSM is IDLE.
        pop_log.delete();
        send(1'b1, 1'b1, 8'h7F);
        idle();
        check("w1_data", 32'(data_o), 32'h7F);
        check("w1_len", 32'(len_o), 32'd1);
        send(1'b1, 1'b0, 8'h50);
        send(1'b0, 1'b1, 8'h51);
        idle();
        repeat (3) @(negedge clk);
        check("w1_entry", 32'(log_at(0)), 32'h017F);
        check("w1_next", 32'(log_at(1)), 32'h0251);
        check("w1_err", 32'(err_o), 32'd0);

        // Back-pressure: fill the FIFO, hold the 5th word, then drain.
        rtr_i = 1'b0;
        pop_log.delete();
        fork
            begin
                for (int i = 1; i <= 5; i++) send(1'b1, 1'b1, 8'(8'h40 + i));
            end
            begin
                repeat (8) @(negedge clk);
                check("full_rtr", 32'(rtr_o), 32'd0);
                check("full_rts", 32'(rts_o), 32'd1);
                check("full_head", 32'(data_o), 32'h41);
                rtr_i = 1'b1;
            end
        join
        idle();
        repeat (8) @(negedge clk);
        check("full_count", 32'(pop_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("full_order", 32'(log_at(i)), 32'(16'h0141 + i));

        // Framing errors: orphan word, then restarted window.
        pop_log.delete();
        send(1'b0, 1'b0, 8'h01);
        send(1'b1, 1'b0, 8'h02);
        send(1'b1, 1'b0, 8'h03);
        send(1'b0, 1'b1, 8'h04);
        idle();
        repeat (3) @(negedge clk);
        check("err_flag", 32'(err_o), 32'd1);
        check("err_count", 32'(pop_log.size()), 32'd1);
        check("err_entry", 32'(log_at(0)), 32'h0204);

        // 300-word window saturates the length counter.
        pop_log.delete();
        send(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 298; i++) send(1'b0, 1'b0, 8'(i));
        send(1'b0, 1'b1, 8'hAB);
        idle();
        repeat (3) @(negedge clk);
        check("sat_count", 32'(pop_log.size()), 32'd1);
        check("sat_entry", 32'(log_at(0)), 32'hFFAB);

        // Asynchronous reset with stored entries and an open window.
        rtr_i = 1'b0;
        send(1'b1, 1'b1, 8'h61);
        send(1'b1, 1'b1, 8'h62);
        send(1'b1, 1'b0, 8'h63);
        send(1'b0, 1'b0, 8'h64);
        idle();
        check("pre_rst_rts", 32'(rts_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rtr", 32'(rtr_o), 32'd0);
        check("async_rts", 32'(rts_o), 32'd0);
        check("async_data", 32'(data_o), 32'd0);
        check("async_len", 32'(len_o), 32'd0);
        check("async_err", 32'(err_o), 32'd0);
        repeat (2) @(negedge clk);
        pop_log.delete();
        rst_n = 1'b1;
        rtr_i = 1'b1;
        send(1'b1, 1'b0, 8'h71);
        send(1'b0, 1'b1, 8'h72);
        idle();
        repeat (4) @(negedge clk);
        check("rst_count", 32'(pop_log.size()), 32'd1);
        check("rst_entry", 32'(log_at(0)), 32'h0272);
        check("rst_err_clear", 32'(err_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/posit_window_collector.md
POSIT_WINDOW_COLLECTOR -- requirements
Module: posit_window_collector

Interface
REQ-001 SHALL have parameter POSIT_WIDTH, default 8, the posit word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the number of stored window results; legal range 2..16.
REQ-003 SHALL have parameter LEN_W, default 8, the width of the window-length counter.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port rts_i, input, 1 bit, upstream word valid (accumulator rts_o).
REQ-007 SHALL have port sow_i, input, 1 bit, the word is the first of a window.
REQ-008 SHALL have port eow_i, input, 1 bit, the word is the last of a window.
REQ-009 SHALL have port data_i, input, POSIT_WIDTH bits, the running accumulated posit.
REQ-010 SHALL have port rtr_o, output, 1 bit, ready to receive from upstream.
REQ-011 SHALL have port rts_o, output, 1 bit, a window result is available.
REQ-012 SHALL have port data_o, output, POSIT_WIDTH bits, the final posit of the oldest stored window.
REQ-013 SHALL have port len_o, output, LEN_W bits, the word count of that window.
REQ-014 SHALL have port rtr_i, input, 1 bit, downstream ready.
REQ-015 SHALL have port err_o, output, 1 bit, sticky framing-error flag.

Function
REQ-016 SHALL accept an input word only in a cycle where rts_i and rtr_o are both 1; otherwise the inputs are ignored.
REQ-017 SHALL drive rtr_o from a register equal to (occupancy < FIFO_DEPTH), evaluated on the post-edge occupancy.
REQ-018 SHALL implement a two-state framing FSM:
- IDLE to IN_WIN on an accepted word with sow_i=1 and eow_i=0.
- IN_WIN to IDLE on an accepted word with eow_i=1.
- All other accepted words leave the state unchanged.
REQ-019 SHALL maintain a length counter:
- Load 1 on an accepted sow_i word.
- Increment by 1 on other accepted words while in IN_WIN.
- Saturate at 2^LEN_W-1 with no wrap.
REQ-020 SHALL write {length including the current word, data_i} into the FIFO on every accepted word with eow_i=1, when the FSM is in IN_WIN or sow_i=1.
REQ-021 SHALL treat an accepted word with sow_i=1 and eow_i=1 as a length-1 window: it is stored, and the FSM ends in IDLE.
REQ-022 SHALL discard accepted words with eow_i=0 without storing them.
REQ-023 SHALL set err_o on any of the following, which stays 1 until reset:
- An accepted word in IDLE with sow_i=0; the word is discarded, including when eow_i=1, and the state is unchanged.
- An accepted sow_i word in IN_WIN; the window restarts with length 1 and is not stored.
REQ-024 SHALL drive rts_o = (occupancy > 0), with data_o and len_o showing the head entry combinationally from registers.
REQ-025 SHALL pop the head entry on a cycle where rts_o and rtr_i are both 1.
REQ-026 SHALL give a latency of exactly 1 cycle: an eow word accepted at edge N produces rts_o=1 after edge N when the FIFO was empty; there is no combinational bypass.
REQ-027 SHALL apply a simultaneous push and pop in the same cycle with occupancy unchanged; this is legal at any occupancy, including FIFO_DEPTH-1.
REQ-028 SHALL hold data_o and len_o stable while rts_o=1 and rtr_i=0.
REQ-029 SHALL use wrap-around read and write pointers modulo FIFO_DEPTH, correct for non-power-of-two depths.

Reset
REQ-030 SHALL, while rst_n=0, immediately force the following, regardless of clk:
- rtr_o=0, rts_o=0, data_o=0, len_o=0, err_o=0.
- FSM=IDLE, length=0, pointers=0, occupancy=0.
REQ-031 SHALL, on reset mid-window or with a non-empty FIFO, discard all stored and partial results.
REQ-032 SHALL assert rtr_o=1 at the first rising edge after rst_n deasserts.

Verification
REQ-033 Window {sow,0x10},{0x20},{eow,0x35}, rtr_i=1 -> one output, data_o=0x35, len_o=3, rts_o high for 1 cycle, err_o=0.
REQ-034 Single word with sow=eow=1, data 0x7F -> data_o=0x7F, len_o=1, FSM returns to IDLE.
REQ-035 rtr_i=0, five 1-word windows at FIFO_DEPTH=4 -> rtr_o=0 after the 4th store; the 5th word is held upstream; releasing rtr_i drains in order, then the 5th is accepted.
REQ-036 A word without sow in IDLE, then sow, sow, eow (data 0x01,0x02,0x03,0x04) -> err_o=1, one stored entry 0x04 with len_o=2.
REQ-037 Window of 300 words at LEN_W=8 -> len_o=255.
REQ-038 rst_n pulsed low with 2 entries stored and a window open -> all outputs 0 during reset; the next full window yields exactly one output.
